data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_LOCK, default 8, maximum accepted beats per lock before forced release (1..255).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have, for n in {0,1}, ports rn_req in 1, rn_we in 1, rn_addr in ADDR_W, rn_wdata in DATA_W, rn_lock in 1: requester n access request.
REQ-007 SHALL have, for n in {0,1}, ports rn_gnt out 1 (request accepted this cycle), rn_done out 1 (access completed), rn_rdata out DATA_W (read result).
REQ-008 SHALL have ports mem_addr out ADDR_W, mem_should_write out 1, mem_write_data out DATA_W, mem_read_data in DATA_W: shared memory port (combinational read, write committed by memory within the cycle).
REQ-009 SHALL have port busy  out  1  high while an access is in the memory stage or a lock is held.

Function
REQ-010 SHALL treat a request as accepted in any cycle where rn_req=1 and rn_gnt=1; rn_gnt SHALL be combinational from current req and state, at most one gnt high per cycle.
REQ-011 Requesters SHALL hold req/we/addr/wdata/lock stable until gnt; arbiter SHALL latch them on the accepting edge.
REQ-012 SHALL issue the latched access on the memory port in the cycle after acceptance (memory stage): mem_addr=latched addr, mem_write_data=latched wdata, mem_should_write=latched we.
REQ-013 When no access is in the memory stage, mem_should_write SHALL be 0; mem_addr and mem_write_data SHALL hold their last values.
REQ-014 At the end of the memory stage, for reads SHALL capture mem_read_data into rn_rdata; for writes rn_rdata SHALL be unchanged.
REQ-015 rn_done SHALL pulse for exactly one cycle, the cycle after the memory stage; latency accept→done = 2 cycles.
REQ-016 SHALL accept a new request in the same cycle an access occupies the memory stage; sustained throughput 1 access/cycle.
REQ-017 Arbitration SHALL be round-robin: with both requesting and no lock held, grant the requester not granted most recently; single requester is granted immediately.
REQ-018 State machine SHALL have states OPEN and LOCKED(n); OPEN→LOCKED(n) on accepting a request from n with rn_lock=1.
REQ-019 In LOCKED(n) only requester n SHALL be granted; the other requester's gnt SHALL stay 0 regardless of its req.
REQ-020 LOCKED(n)→OPEN on accepting a request from n with rn_lock=0 (that beat included), or on the MAX_LOCK-th accepted beat since entry, whichever first.
REQ-021 On forced release (MAX_LOCK reached), the most-recent pointer SHALL equal n so the other requester wins the next tie.
REQ-022 A lock beat count SHALL count accepted beats only; idle cycles in LOCKED(n) SHALL not count or release the lock.
REQ-023 busy SHALL equal (memory stage occupied) OR (state is LOCKED).

Reset
REQ-024 While reset=1: state OPEN, most-recent pointer = 1 (r0 wins first tie), lock count 0, memory stage empty, all gnt/done/mem_should_write/busy 0, mem_addr/mem_write_data/rn_rdata 0.
REQ-025 Reset asserted with an access in the memory stage SHALL abandon it: mem_should_write 0 in the reset cycle, no done pulse afterwards.
REQ-026 gnt SHALL be 0 during reset cycles; no request SHALL be accepted.

Verification
REQ-027 r0 write addr 0x10 data 0xDEADBEEF at T → r0_gnt@T, mem_should_write=1 mem_addr=0x10@T+1, r0_done@T+2, r0_rdata unchanged.
REQ-028 r0 and r1 request reads every cycle after reset → grants alternate r0,r1,r0,...; each done exactly 2 cycles after its gnt; rdata matches memory contents.
REQ-029 r1 locked read-modify-write (read lock=1, write lock=0) while r0 requests continuously → r0_gnt=0 until r1's unlocked beat accepted; r0 granted next cycle.
REQ-030 MAX_LOCK=4, r0 holds lock=1 for 6 beats, r1 requesting → after r0's 4th accepted beat state OPEN and r1 granted next.
REQ-031 reset asserted in cycle with a write in memory stage → mem_should_write=0 that cycle, no done, all outputs at reset values next cycle.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundle of every signal between the two requesters, the shared memory port
// and the arbiter.
//   r0_*/r1_* req, we, addr, wdata, lock : request side (into the arbiter)
//   r0_*/r1_* gnt, done, rdata           : response side (out of the arbiter)
//   mem_addr, mem_should_write,
//   mem_write_data                       : shared memory port (out of arbiter)
//   mem_read_data                        : combinational memory read data
//   busy                                 : access in flight or lock held
// Modports: slave = arbiter, master = requesters plus memory.
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_lock;
  logic              r0_gnt;
  logic              r0_done;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_lock;
  logic              r1_gnt;
  logic              r1_done;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_should_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    input  mem_read_data,
    output r0_gnt, r0_done, r0_rdata,
    output r1_gnt, r1_done, r1_rdata,
    output mem_addr, mem_should_write, mem_write_data,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    output mem_read_data,
    input  r0_gnt, r0_done, r0_rdata,
    input  r1_gnt, r1_done, r1_rdata,
    input  mem_addr, mem_should_write, mem_write_data,
    input  busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Two-requester round-robin arbiter in front of a single-ported data memory,
// with bus locking for atomic sequences.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : data_mem_arbiter_if.slave (requests, responses, memory port, busy)
// Pipeline: accept (gnt) -> memory stage (next cycle) -> done pulse (cycle
// after). One access per cycle sustained.
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input logic clk,
  input logic reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t            state;
  logic              last_gnt;   // requester granted most recently
  logic [7:0]        lock_cnt;   // accepted beats since lock entry

  // Memory stage registers
  logic              ms_valid;
  logic              ms_id;
  logic              ms_we;
  logic [ADDR_W-1:0] ms_addr;
  logic [DATA_W-1:0] ms_wdata;

  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  logic              gnt0;
  logic              gnt1;

  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        OPEN: begin
          if (bus.r0_req && bus.r1_req) begin
            // Tie: the requester not granted most recently wins.
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = bus.r0_req;
            gnt1 = bus.r1_req;
          end
        end
        LOCKED0: gnt0 = bus.r0_req;
        LOCKED1: gnt1 = bus.r1_req;
        default: ;
      endcase
    end
  end

  // Mux of the accepted request; at most one grant is ever high.
  logic              acc;
  logic              acc_id;
  logic              acc_we;
  logic              acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign acc       = gnt0 | gnt1;
  assign acc_id    = gnt1;
  assign acc_we    = gnt1 ? bus.r1_we    : bus.r0_we;
  assign acc_lock  = gnt1 ? bus.r1_lock  : bus.r0_lock;
  assign acc_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign acc_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OPEN;
      last_gnt <= 1'b1;
      lock_cnt <= 8'd0;
      ms_valid <= 1'b0;
      ms_id    <= 1'b0;
      ms_we    <= 1'b0;
      ms_addr  <= '0;
      ms_wdata <= '0;
      done_q   <= 2'b00;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      ms_valid <= acc;
      if (acc) begin
        ms_id    <= acc_id;
        ms_we    <= acc_we;
        ms_addr  <= acc_addr;
        ms_wdata <= acc_wdata;
      end

      done_q[0] <= ms_valid && !ms_id;
      done_q[1] <= ms_valid &&  ms_id;

      if (ms_valid && !ms_we) begin
        if (ms_id) rdata1 <= bus.mem_read_data;
        else       rdata0 <= bus.mem_read_data;
      end

      if (acc) begin
        // Also leaves the pointer at n on forced release, so the other
        // requester wins the next tie.
        last_gnt <= acc_id;
        if (state == OPEN) begin
          // The entering beat is the first beat of the lock.
          if (acc_lock && MAX_LOCK_C != 8'd1) begin
            state    <= acc_id ? LOCKED1 : LOCKED0;
            lock_cnt <= 8'd1;
          end
        end else if (!acc_lock || (lock_cnt + 8'd1 == MAX_LOCK_C)) begin
          // Only the owner can be granted while locked.
          state    <= OPEN;
          lock_cnt <= 8'd0;
        end else begin
          lock_cnt <= lock_cnt + 8'd1;
        end
      end
    end
  end

  // The synchronous reset only clears registers at the edge, so the flags
  // are masked directly to stay quiet during the reset cycle itself; this
  // is what abandons a write sitting in the memory stage.
  assign bus.r0_gnt           = gnt0;
  assign bus.r1_gnt           = gnt1;
  assign bus.r0_done          = done_q[0] && !reset;
  assign bus.r1_done          = done_q[1] && !reset;
  assign bus.r0_rdata         = rdata0;
  assign bus.r1_rdata         = rdata1;
  assign bus.mem_addr         = ms_addr;
  assign bus.mem_write_data   = ms_wdata;
  assign bus.mem_should_write = ms_valid && ms_we && !reset;
  assign bus.busy             = !reset && (ms_valid || state != OPEN);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Self-checking bench: a monitor pushes each observed grant into a memory
// stage queue, checks the memory port one cycle later against a shadow
// memory, then checks the done pulse and read data one cycle after that.
// Directed sequences check arbitration, locking and reset behaviour.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write committed at the edge.
  logic [DW-1:0] mem    [16];
  logic [DW-1:0] shadow [16];

  assign bus.mem_read_data = mem[bus.mem_addr[5:2]];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    forever begin
      @(posedge clk);
      if (bus.mem_should_write) mem[bus.mem_addr[5:2]] <= bus.mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Scoreboard
  typedef struct {
    int          due;
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ms_ent_t;

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] rdata;
  } dn_ent_t;

  ms_ent_t     ms_q [$];
  dn_ent_t     dn_q [$];
  logic [31:0] exp_rdata [2];

  always @(negedge clk) begin : monitor
    ms_ent_t m;
    dn_ent_t d;
    bit      exp_d [2];
    if (reset) begin
      check("rst_gnt",  32'({bus.r1_gnt, bus.r0_gnt}), 32'd0);
      check("rst_done", 32'({bus.r1_done, bus.r0_done}), 32'd0);
      check("rst_mem_we", 32'(bus.mem_should_write), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      ms_q.delete();
      dn_q.delete();
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
    end else begin
      exp_d[0] = 1'b0;
      exp_d[1] = 1'b0;
      while (dn_q.size() > 0 && dn_q[0].due == cyc) begin
        d = dn_q.pop_front();
        exp_d[d.id] = 1'b1;
        if (d.id) check("r1_rdata", bus.r1_rdata, d.rdata);
        else      check("r0_rdata", bus.r0_rdata, d.rdata);
      end
      check("r0_done", 32'(bus.r0_done), 32'(exp_d[0]));
      check("r1_done", 32'(bus.r1_done), 32'(exp_d[1]));

      if (ms_q.size() > 0 && ms_q[0].due == cyc) begin
        m = ms_q.pop_front();
        check("ms_we", 32'(bus.mem_should_write), 32'(m.we));
        check("ms_addr", bus.mem_addr, m.addr);
        if (m.we) begin
          check("ms_wdata", bus.mem_write_data, m.wdata);
          shadow[m.addr[5:2]] = m.wdata;
        end else begin
          exp_rdata[m.id] = shadow[m.addr[5:2]];
        end
        d.due   = cyc + 1;
        d.id    = m.id;
        d.rdata = exp_rdata[m.id];
        dn_q.push_back(d);
      end else begin
        check("idle_mem_we", 32'(bus.mem_should_write), 32'd0);
      end

      check("one_gnt", 32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
      if (bus.r0_gnt) begin
        m.due = cyc + 1; m.id = 1'b0; m.we = bus.r0_we;
        m.addr = bus.r0_addr; m.wdata = bus.r0_wdata;
        ms_q.push_back(m);
      end
      if (bus.r1_gnt) begin
        m.due = cyc + 1; m.id = 1'b1; m.we = bus.r1_we;
        m.addr = bus.r1_addr; m.wdata = bus.r1_wdata;
        ms_q.push_back(m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_lock = 1'b0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_lock = 1'b0;
  endtask

  task automatic drive(input bit id, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit lock);
    if (id) begin
      bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr;
      bus.r1_wdata = wdata; bus.r1_lock = lock;
    end else begin
      bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr;
      bus.r0_wdata = wdata; bus.r0_lock = lock;
    end
  endtask

  task automatic do_reset();
    tick();
    idle_reqs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int i0;
    int i1;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h1000_0000 + 32'(i);
    idle_reqs();
    bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_addr = '0; bus.r1_wdata = '0;

    // Reset state
    reset = 1'b1;
    tick();
    sample();
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
    check("rst_r0_rdata", bus.r0_rdata, 32'd0);
    check("rst_r1_rdata", bus.r1_rdata, 32'd0);
    tick();
    reset = 1'b0;

    // Single write from r0
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    sample();
    check("wr_r0_gnt", 32'(bus.r0_gnt), 32'd1);
    tick();
    idle_reqs();
    sample();
    check("wr_busy_ms", 32'(bus.busy), 32'd1);
    check("wr_mem_we", 32'(bus.mem_should_write), 32'd1);
    tick();
    sample();
    check("wr_done", 32'(bus.r0_done), 32'd1);
    check("wr_rdata_keep", bus.r0_rdata, 32'd0);
    check("wr_busy_idle", 32'(bus.busy), 32'd0);

    // Round robin, both reading every cycle
    do_reset();
    i0 = 0;
    i1 = 8;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 32'(i0 * 4), 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'(i1 * 4), 32'd0, 1'b0);
      sample();
      check("rr_r0_gnt", 32'(bus.r0_gnt), 32'((k % 2) == 0));
      check("rr_r1_gnt", 32'(bus.r1_gnt), 32'((k % 2) == 1));
      if (bus.r0_gnt) i0 = (i0 + 1) % 16;
      if (bus.r1_gnt) i1 = (i1 + 1) % 16;
      tick();
    end
    idle_reqs();
    repeat (3) tick();

    // r1 locked read-modify-write against a continuous r0
    do_reset();
    drive(1'b0, 1'b0, 32'h20, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'h14, 32'd0, 1'b1);
    sample();
    check("rmw_c0_r0", 32'(bus.r0_gnt), 32'd1);
    tick();
    sample();
    check("rmw_c1_r1", 32'(bus.r1_gnt), 32'd1);
    check("rmw_c1_r0", 32'(bus.r0_gnt), 32'd0);
    tick();
    bus.r1_req = 1'b0;
    sample();
    check("rmw_idle_r0_a", 32'(bus.r0_gnt), 32'd0);
    tick();
    sample();
    check("rmw_idle_r0_b", 32'(bus.r0_gnt), 32'd0);
    check("rmw_lock_busy", 32'(bus.busy), 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h14, 32'hCAFE0001, 1'b0);
    sample();
    check("rmw_wr_r1", 32'(bus.r1_gnt), 32'd1);
    check("rmw_wr_r0", 32'(bus.r0_gnt), 32'd0);
    tick();
    bus.r1_req = 1'b0;
    sample();
    check("rmw_after_r0", 32'(bus.r0_gnt), 32'd1);
    tick();
    idle_reqs();
    tick();
    tick();
    sample();
    check("rmw_busy_end", 32'(bus.busy), 32'd0);

    // Forced release after MAX_LOCK=4 beats
    do_reset();
    drive(1'b0, 1'b0, 32'h08, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 32'h0C, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("ml_r0_gnt", 32'(bus.r0_gnt), 32'd1);
      check("ml_r1_blk", 32'(bus.r1_gnt), 32'd0);
      tick();
    end
    sample();
    check("ml_r1_wins", 32'(bus.r1_gnt), 32'd1);
    check("ml_r0_wait", 32'(bus.r0_gnt), 32'd0);
    tick();
    bus.r1_req = 1'b0;
    sample();
    check("ml_beat5", 32'(bus.r0_gnt), 32'd1);
    tick();
    sample();
    check("ml_beat6", 32'(bus.r0_gnt), 32'd1);
    tick();
    idle_reqs();
    tick();
    tick();
    sample();
    check("ml_relock_busy", 32'(bus.busy), 32'd1);

    // Reset while a write sits in the memory stage
    tick();
    drive(1'b0, 1'b1, 32'h30, 32'h5555AAAA, 1'b0);
    sample();
    check("rw_gnt", 32'(bus.r0_gnt), 32'd1);
    tick();
    idle_reqs();
    reset = 1'b1;
    sample();
    check("rw_mem_we", 32'(bus.mem_should_write), 32'd0);
    check("rw_done", 32'(bus.r0_done), 32'd0);
    tick();
    reset = 1'b0;
    sample();
    check("rw_post_addr", bus.mem_addr, 32'd0);
    check("rw_post_wdata", bus.mem_write_data, 32'd0);
    check("rw_post_rdata", bus.r0_rdata, 32'd0);
    check("rw_post_busy", 32'(bus.busy), 32'd0);
    check("rw_post_done", 32'(bus.r0_done), 32'd0);
    tick();
    sample();
    check("rw_no_late_done", 32'(bus.r0_done), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h30, 32'd0, 1'b0);
    sample();
    check("rw_rd_gnt", 32'(bus.r0_gnt), 32'd1);
    tick();
    idle_reqs();
    tick();
    sample();
    check("rw_not_written", bus.r0_rdata, 32'h1000_000C);

    repeat (3) tick();
    sample();
    check("sb_drained", 32'(ms_q.size() + dn_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
